// File: rtl/mult_share_arb_if.sv
// Request/response bundle between requesters and the shared multiplier.
// Requesters and the response consumer sit on the master side.
interface mult_share_arb_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_a;
    logic [3*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [7:0]        rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin shared 5x3 signed multiplier front end.
// Two stages: operand register feeding the array, then carry-save sum.
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    mult_share_arb_if.slave bus,
    output logic [4:0]      mult_a,
    output logic [2:0]      mult_b,
    input  logic [7:0]      mult_out1,
    input  logic [7:0]      mult_out2
);
    typedef struct packed {
        logic [4:0]      a;
        logic [2:0]      b;
        logic [ID_W-1:0] id;
        logic            v;
    } s1_t;

    typedef struct packed {
        logic [7:0]      prod;
        logic [ID_W-1:0] id;
        logic            v;
    } s2_t;

    s1_t             s1;
    s2_t             s2;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] win;
    logic            any;
    logic            adv1;
    logic            adv2;

    assign adv2 = !s2.v || bus.rsp_ready;
    assign adv1 = !s1.v || adv2;

    // Search starts just after the last winner and wraps.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && bus.req_valid[(int'(last) + k) % NREQ]) begin
                any = 1'b1;
                win = ID_W'((int'(last) + k) % NREQ);
            end
        end
    end

    assign bus.req_ready = (adv1 && any) ? (NREQ'(1) << win) : '0;

    assign mult_a        = s1.a;
    assign mult_b        = s1.b;
    assign bus.rsp_valid = s2.v;
    assign bus.rsp_id    = s2.id;
    assign bus.rsp_prod  = s2.prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            last <= ID_W'(NREQ - 1);
        end else begin
            if (adv2) begin
                s2.prod <= mult_out1 + mult_out2;
                s2.id   <= s1.id;
                s2.v    <= s1.v;
            end
            if (adv1) begin
                s1.v <= any;
                if (any) begin
                    s1.a  <= bus.req_a[5*int'(win) +: 5];
                    s1.b  <= bus.req_b[3*int'(win) +: 3];
                    s1.id <= win;
                    last  <= win;
                end
            end
        end
    end
endmodule
